// File: rtl/i2c_core_pkg.sv
// ============================================================================
// Module   : i2c_core_pkg
// Brief    : Shared I2C core types: FSM state encoding, SDA-select codes and
//            the bit-counter width helper used by FSM and data path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_core_pkg;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDR       = 4'd2,
    ST_ADDR_ACK   = 4'd3,
    ST_WRITE_DATA = 4'd4,
    ST_WRITE_ACK  = 4'd5,
    ST_READ_DATA  = 4'd6,
    ST_READ_ACK   = 4'd7,
    ST_STOP       = 4'd8
  } i2c_state_e;

  // What the data path puts on SDA in the current bit slot.
  typedef enum logic [2:0] {
    SDA_SEL_RELEASE = 3'd0,
    SDA_SEL_LOW     = 3'd1,
    SDA_SEL_ADDR    = 3'd2,
    SDA_SEL_DATA    = 3'd3,
    SDA_SEL_RECEIVE = 3'd4
  } sda_sel_e;

endpackage

`default_nettype wire

// File: rtl/i2c_master_fsm_if.sv
// ============================================================================
// Module   : i2c_master_fsm_if
// Brief    : Control/handshake bundle between the I2C master FSM and its
//            data path and FIFO neighbours.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i2c_master_fsm_if #(
  parameter int DATA_SIZE = 8
);
  import i2c_core_pkg::*;

  localparam int CNT_W = cnt_width(DATA_SIZE);

  logic             enable_i;
  logic             rw_i;
  logic             i2c_sda_i;
  logic             tx_fifo_empty_i;
  logic             rx_fifo_afull_i;
  logic             sda_low_en_o;
  logic             write_addr_en_o;
  logic             write_data_en_o;
  logic             receive_data_en_o;
  logic [CNT_W-1:0] count_bit_o;
  logic             scl_en_o;
  logic             tx_rd_en_o;
  logic             rx_wr_en_o;
  logic             busy_o;
  logic             ack_err_o;
  logic             done_o;

  modport master (
    input  enable_i, rw_i, i2c_sda_i, tx_fifo_empty_i, rx_fifo_afull_i,
    output sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o,
           count_bit_o, scl_en_o, tx_rd_en_o, rx_wr_en_o, busy_o, ack_err_o,
           done_o
  );

  modport slave (
    output enable_i, rw_i, i2c_sda_i, tx_fifo_empty_i, rx_fifo_afull_i,
    input  sda_low_en_o, write_addr_en_o, write_data_en_o, receive_data_en_o,
           count_bit_o, scl_en_o, tx_rd_en_o, rx_wr_en_o, busy_o, ack_err_o,
           done_o
  );

endinterface

`default_nettype wire

// File: rtl/i2c_bit_counter.sv
// ============================================================================
// Module   : i2c_bit_counter
// Brief    : Bit-index down counter with load, decrement and zero flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_bit_counter #(
  parameter int               WIDTH      = 3,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VALUE;
    end else if (dec_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= LOAD_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/i2c_master_fsm.sv
// ============================================================================
// Module   : i2c_master_fsm
// Brief    : I2C master control FSM: START, address, ACK, data, STOP sequencing
//            with SDA-select, SCL gating and FIFO handshakes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_master_fsm #(
  parameter int DATA_SIZE = 8
) (
  input  logic               i2c_core_clk_i,
  input  logic               reset_ni,
  i2c_master_fsm_if.master   bus
);
  import i2c_core_pkg::*;

  localparam int               CNT_W    = cnt_width(DATA_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_SIZE - 1);

  i2c_state_e       state_q, state_d;
  logic             rw_q, rw_d;
  logic             ack_err_q, ack_err_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count;
  logic             count_zero;
  logic             in_byte;
  logic             read_ack_ok;
  sda_sel_e         sda_sel;
  logic             scl_en;
  logic             tx_rd_en;
  logic             rx_wr_en;

  assign in_byte     = (state_q == ST_ADDR) || (state_q == ST_WRITE_DATA) ||
                       (state_q == ST_READ_DATA);
  assign read_ack_ok = bus.enable_i && !bus.rx_fifo_afull_i;

  // Outside byte states the counter sits preloaded, so every byte starts at MSB.
  i2c_bit_counter #(
    .WIDTH      (CNT_W),
    .LOAD_VALUE (CNT_LOAD)
  ) u_bit_counter (
    .clk_i    (i2c_core_clk_i),
    .reset_ni (reset_ni),
    .load_i   (!in_byte),
    .dec_i    (in_byte && !count_zero),
    .count_o  (count),
    .zero_o   (count_zero)
  );

  always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          state_d   = ST_START;
          rw_d      = bus.rw_i;
          ack_err_d = 1'b0;
        end
      end
      ST_START: state_d = ST_ADDR;
      ST_ADDR: begin
        if (count_zero) state_d = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        if (bus.i2c_sda_i) begin
          ack_err_d = 1'b1;
          state_d   = ST_STOP;
        end else if (rw_q) begin
          state_d = ST_READ_DATA;
        end else if (!bus.tx_fifo_empty_i) begin
          state_d = ST_WRITE_DATA;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WRITE_DATA: begin
        if (count_zero) state_d = ST_WRITE_ACK;
      end
      ST_WRITE_ACK: begin
        if (bus.i2c_sda_i) begin
          ack_err_d = 1'b1;
          state_d   = ST_STOP;
        end else if (bus.enable_i && !bus.tx_fifo_empty_i) begin
          state_d = ST_WRITE_DATA;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_READ_DATA: begin
        if (count_zero) state_d = ST_READ_ACK;
      end
      ST_READ_ACK: begin
        state_d = read_ack_ok ? ST_READ_DATA : ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sda_sel  = SDA_SEL_RELEASE;
    scl_en   = 1'b0;
    tx_rd_en = 1'b0;
    rx_wr_en = 1'b0;
    case (state_q)
      ST_START, ST_STOP: sda_sel = SDA_SEL_LOW;
      ST_ADDR: begin
        sda_sel = SDA_SEL_ADDR;
        scl_en  = 1'b1;
      end
      ST_ADDR_ACK, ST_WRITE_ACK: scl_en = 1'b1;
      ST_WRITE_DATA: begin
        sda_sel  = SDA_SEL_DATA;
        scl_en   = 1'b1;
        tx_rd_en = count_zero;
      end
      ST_READ_DATA: begin
        sda_sel = SDA_SEL_RECEIVE;
        scl_en  = 1'b1;
      end
      ST_READ_ACK: begin
        // Master ACK only when another byte is both wanted and storable.
        sda_sel  = read_ack_ok ? SDA_SEL_LOW : SDA_SEL_RELEASE;
        scl_en   = 1'b1;
        rx_wr_en = 1'b1;
      end
      default: sda_sel = SDA_SEL_RELEASE;
    endcase
  end

  assign bus.sda_low_en_o      = (sda_sel == SDA_SEL_LOW);
  assign bus.write_addr_en_o   = (sda_sel == SDA_SEL_ADDR);
  assign bus.write_data_en_o   = (sda_sel == SDA_SEL_DATA);
  assign bus.receive_data_en_o = (sda_sel == SDA_SEL_RECEIVE);
  assign bus.count_bit_o       = count;
  assign bus.scl_en_o          = scl_en;
  assign bus.tx_rd_en_o        = tx_rd_en;
  assign bus.rx_wr_en_o        = rx_wr_en;
  assign bus.busy_o            = (state_q != ST_IDLE);
  assign bus.ack_err_o         = ack_err_q;
  assign bus.done_o            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_fsm.sv
// ============================================================================
// Module   : tb_i2c_master_fsm
// Brief    : Scoreboard bench for i2c_master_fsm: per-cycle expected outputs
//            queued with the stimulus, compared at the falling clock edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_master_fsm;

  typedef struct packed {
    logic       sda_low;
    logic       waddr;
    logic       wdata;
    logic       rdata;
    logic [2:0] cnt;
    logic       scl;
    logic       txrd;
    logic       rxwr;
    logic       busy;
    logic       err;
    logic       done;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    cc;
    string nm;
  } exp_t;

  logic  clk;
  logic  reset_ni;
  int    checks;
  int    errors;
  logic  err_now;
  exp_t  exp_q[$];

  i2c_master_fsm_if #(.DATA_SIZE(8)) bus ();

  i2c_master_fsm #(.DATA_SIZE(8)) dut (
    .i2c_core_clk_i (clk),
    .reset_ni       (reset_ni),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic outs_t sample();
    outs_t o;
    o.sda_low = bus.sda_low_en_o;
    o.waddr   = bus.write_addr_en_o;
    o.wdata   = bus.write_data_en_o;
    o.rdata   = bus.receive_data_en_o;
    o.cnt     = bus.count_bit_o;
    o.scl     = bus.scl_en_o;
    o.txrd    = bus.tx_rd_en_o;
    o.rxwr    = bus.rx_wr_en_o;
    o.busy    = bus.busy_o;
    o.err     = bus.ack_err_o;
    o.done    = bus.done_o;
    return o;
  endfunction

  function automatic outs_t o_idle(input logic err, input logic done);
    outs_t o = '0;
    o.cnt = 3'd7; o.err = err; o.done = done;
    return o;
  endfunction

  function automatic outs_t o_start();
    outs_t o = '0;
    o.sda_low = 1'b1; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_addr(input int c);
    outs_t o = '0;
    o.waddr = 1'b1; o.scl = 1'b1; o.busy = 1'b1; o.cnt = 3'(c);
    return o;
  endfunction

  function automatic outs_t o_ack(input logic err);
    outs_t o = '0;
    o.scl = 1'b1; o.busy = 1'b1; o.err = err;
    return o;
  endfunction

  function automatic outs_t o_wdata(input int c);
    outs_t o = '0;
    o.wdata = 1'b1; o.scl = 1'b1; o.busy = 1'b1; o.cnt = 3'(c);
    o.txrd  = (c == 0);
    return o;
  endfunction

  function automatic outs_t o_rdata(input int c);
    outs_t o = '0;
    o.rdata = 1'b1; o.scl = 1'b1; o.busy = 1'b1; o.cnt = 3'(c);
    return o;
  endfunction

  function automatic outs_t o_rack(input logic ack);
    outs_t o = '0;
    o.rxwr = 1'b1; o.scl = 1'b1; o.busy = 1'b1; o.sda_low = ack;
    return o;
  endfunction

  function automatic outs_t o_stop(input logic err);
    outs_t o = '0;
    o.sda_low = 1'b1; o.busy = 1'b1; o.err = err;
    return o;
  endfunction

  // Scoreboard consumer: one queued expectation per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      outs_t act;
      outs_t want;
      e    = exp_q.pop_front();
      act  = sample();
      want = e.o;
      if (!e.cc) begin
        act.cnt  = '0;
        want.cnt = '0;
      end
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s @%0t: got %b required %b (sda,wa,wd,rd,cnt,scl,txrd,rxwr,busy,err,done)",
                 e.nm, $time, act, want);
      end
    end
  end

  task automatic cyc(input logic en, input logic rw, input logic sda,
                     input logic empty, input logic afull,
                     input outs_t o, input bit cc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.enable_i        = en;
    bus.rw_i            = rw;
    bus.i2c_sda_i       = sda;
    bus.tx_fifo_empty_i = empty;
    bus.rx_fifo_afull_i = afull;
    e.o  = o;
    e.cc = cc;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic addr_phase(input logic rw, input logic err_before);
    cyc(1'b1, rw, 1'b1, 1'b0, 1'b0, o_idle(err_before, 1'b0), 1'b0, "idle");
    cyc(1'b1, rw, 1'b1, 1'b0, 1'b0, o_start(), 1'b0, "start");
    for (int c = 7; c >= 0; c--)
      cyc(1'b1, rw, 1'b1, 1'b0, 1'b0, o_addr(c), 1'b1, "addr");
  endtask

  task automatic end_phase(input logic err);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o_stop(err), 1'b0, "stop");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o_idle(err, 1'b1), 1'b0, "done");
    err_now = err;
  endtask

  task automatic test_reset();
    outs_t want;
    reset_ni            = 1'b0;
    bus.enable_i        = 1'b0;
    bus.rw_i            = 1'b0;
    bus.i2c_sda_i       = 1'b1;
    bus.tx_fifo_empty_i = 1'b1;
    bus.rx_fifo_afull_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    want = o_idle(1'b0, 1'b0);
    checks++;
    if (sample() !== want) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", sample(), want);
    end
    @(negedge clk);
    reset_ni = 1'b1;
    err_now  = 1'b0;
  endtask

  task automatic test_write_two();
    addr_phase(1'b0, err_now);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o_ack(1'b0), 1'b0, "w_addr_ack");
    for (int b = 0; b < 2; b++) begin
      for (int c = 7; c >= 0; c--)
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, o_wdata(c), 1'b1, "w_data");
      cyc(1'b1, 1'b0, 1'b0, (b == 1), 1'b0, o_ack(1'b0), 1'b0, "w_data_ack");
    end
    end_phase(1'b0);
    drain();
  endtask

  task automatic test_addr_nack();
    addr_phase(1'b0, err_now);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, o_ack(1'b0), 1'b0, "nack_addr_ack");
    end_phase(1'b1);
    drain();
  endtask

  task automatic test_read_three();
    addr_phase(1'b1, err_now);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o_ack(1'b0), 1'b0, "r_addr_ack");
    for (int b = 0; b < 3; b++) begin
      for (int c = 7; c >= 0; c--)
        cyc((b != 2), 1'b1, c[0], 1'b0, 1'b0, o_rdata(c), 1'b1, "r_data");
      cyc((b != 2), 1'b1, 1'b1, 1'b0, 1'b0, o_rack(b < 2), 1'b0, "r_ack");
    end
    end_phase(1'b0);
    drain();
  endtask

  task automatic test_read_afull();
    addr_phase(1'b1, err_now);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o_ack(1'b0), 1'b0, "af_addr_ack");
    for (int c = 7; c >= 0; c--)
      cyc(1'b1, 1'b1, ~c[0], 1'b0, 1'b0, o_rdata(c), 1'b1, "af_data");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, o_rack(1'b0), 1'b0, "af_ack");
    end_phase(1'b0);
    drain();
  endtask

  task automatic test_write_empty();
    addr_phase(1'b0, err_now);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, o_ack(1'b0), 1'b0, "empty_addr_ack");
    end_phase(1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    outs_t want;
    addr_phase(1'b0, err_now);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o_ack(1'b0), 1'b0, "rm_addr_ack");
    for (int c = 7; c >= 4; c--)
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, o_wdata(c), 1'b1, "rm_data");
    drain();
    bus.enable_i = 1'b0;
    reset_ni     = 1'b0;
    #1;
    want = o_idle(1'b0, 1'b0);
    checks++;
    if (sample() !== want) begin
      errors++;
      $display("FAIL reset_mid_async: got %b required %b", sample(), want);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b required 0", bus.busy_o);
    end
    @(negedge clk);
    reset_ni = 1'b1;
    err_now  = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o_idle(1'b0, 1'b0), 1'b1, "rm_idle0");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o_idle(1'b0, 1'b0), 1'b1, "rm_idle1");
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_two();
    test_addr_nack();
    test_read_three();
    test_read_afull();
    test_write_empty();
    test_reset_mid();
    test_write_two();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
